// File: rtl/mem_access_unit.sv
// Memory-access stage: passes execute results to writeback or runs one data-bus
// transaction, with load lane extraction, store lane steering and misalign trap.
//
// state | meaning
// IDLE  | ready for a new execute result; retires ALU ops and trapped accesses
// BUS   | bus transaction outstanding, upstream stalled until bus_ack
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       regcData_i,
  input  logic [4:0]        regcAddr_i,
  input  logic              regcWr_i,
  input  logic [ADDR_W-1:0] memAddr_i,
  input  logic [31:0]       memData_i,
  input  logic              readWr_i,
  input  logic              writeWr_i,
  input  logic [3:0]        rmask_i,
  input  logic [3:0]        wmask_i,
  input  logic              load_signed_i,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_addr,
  output logic              wb_wr,
  output logic              misalign
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state, state_nxt;
  logic        accept, is_mem, is_store, aligned;
  logic [3:0]  acc_mask;
  logic [1:0]  lat_off;
  logic [3:0]  lat_mask;
  logic        lat_signed, lat_store, lat_regc_wr;
  logic [31:0] lat_regc_data;
  logic [4:0]  lat_regc_addr;
  logic [31:0] rd_shift, ld_val;

  assign in_ready = (state == IDLE) & ~rst;
  assign accept   = in_valid & in_ready;
  assign is_mem   = readWr_i | writeWr_i;
  assign is_store = writeWr_i;
  assign acc_mask = is_store ? wmask_i : rmask_i;
  assign bus_req  = (state == BUS);

  // Illegal sizes are folded into "not aligned" so they trap the same way.
  always_comb begin
    aligned = 1'b0;
    case (acc_mask)
      4'b0001: aligned = 1'b1;
      4'b0011: aligned = ~memAddr_i[0];
      4'b1111: aligned = (memAddr_i[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mem && aligned) state_nxt = BUS;
      BUS:     if (bus_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_shift = bus_rdata >> {lat_off, 3'b000};

  always_comb begin
    ld_val = rd_shift;
    case (lat_mask)
      4'b0001: ld_val = {{24{lat_signed & rd_shift[7]}}, rd_shift[7:0]};
      4'b0011: ld_val = {{16{lat_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_val = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_wstrb     <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_addr       <= '0;
      wb_wr         <= 1'b0;
      misalign      <= 1'b0;
      lat_off       <= '0;
      lat_mask      <= '0;
      lat_signed    <= 1'b0;
      lat_store     <= 1'b0;
      lat_regc_wr   <= 1'b0;
      lat_regc_data <= '0;
      lat_regc_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      if (accept) begin
        if (!is_mem) begin
          wb_valid <= 1'b1;
          wb_data  <= regcData_i;
          wb_addr  <= regcAddr_i;
          wb_wr    <= regcWr_i;
        end else if (!aligned) begin
          wb_valid <= 1'b1;
          wb_data  <= regcData_i;
          wb_addr  <= regcAddr_i;
          wb_wr    <= 1'b0;
          misalign <= 1'b1;
        end else begin
          bus_we        <= is_store;
          bus_addr      <= {memAddr_i[ADDR_W-1:2], 2'b00};
          bus_wdata     <= is_store ? (memData_i << {memAddr_i[1:0], 3'b000}) : 32'd0;
          bus_wstrb     <= is_store ? (wmask_i << memAddr_i[1:0]) : 4'b0000;
          lat_off       <= memAddr_i[1:0];
          lat_mask      <= rmask_i;
          lat_signed    <= load_signed_i;
          lat_store     <= is_store;
          lat_regc_wr   <= regcWr_i;
          lat_regc_data <= regcData_i;
          lat_regc_addr <= regcAddr_i;
        end
      end else if (state == BUS && bus_ack) begin
        wb_valid <= 1'b1;
        wb_addr  <= lat_regc_addr;
        wb_data  <= lat_store ? lat_regc_data : ld_val;
        wb_wr    <= lat_store ? 1'b0 : lat_regc_wr;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage directly downstream of the execute unit. Takes one execute result per handshake and either passes it straight to writeback or runs a single data-bus transaction. Loads are lane-extracted and extended; stores are lane-shifted and strobed. Misaligned accesses are trapped, and the stage stalls upstream while a bus transaction is outstanding.

## Interface
Parameters:
- ADDR_W, 32, data-bus address width; must equal the execute address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  execute result present
- in_ready  out  1  stage accepts this cycle
- regcData_i  in  32  execute result / writeback data
- regcAddr_i  in  5  destination register
- regcWr_i  in  1  register write enable
- memAddr_i  in  32  byte address
- memData_i  in  32  store data, right-aligned
- readWr_i  in  1  load request
- writeWr_i  in  1  store request
- rmask_i  in  4  load size: 0001 byte, 0011 half, 1111 word
- wmask_i  in  4  store size, same encoding
- load_signed_i  in  1  sign-extend byte/half loads
- bus_req  out  1  transaction request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  32  {memAddr[31:2],2'b00}
- bus_wdata  out  32  lane-shifted store data
- bus_wstrb  out  4  byte strobes; 0 for reads
- bus_ack  in  1  transaction complete; rdata valid same cycle
- bus_rdata  in  32  read data
- wb_valid  out  1  one-cycle retire pulse
- wb_data  out  32  writeback data
- wb_addr  out  5  writeback register
- wb_wr  out  1  writeback enable
- misalign  out  1  one-cycle pulse with the retiring misaligned access

## Operation
- States are IDLE and BUS. `in_ready = (state==IDLE) & ~rst`.
- IDLE, accept (`in_valid & in_ready`):
  - No memory op (`readWr_i=writeWr_i=0`): register regcData_i/regcAddr_i/regcWr_i into wb_*. Set wb_valid=1 next cycle. Stay in IDLE.
  - Memory op, aligned: latch all inputs and go to BUS.
  - Memory op, misaligned or illegal size: next cycle wb_valid=1, wb_wr=0, misalign=1, no bus activity. Stay in IDLE.
  - Alignment rules: half needs addr[0]=0; word needs addr[1:0]=0. A mask outside {0001,0011,1111} is illegal.
- Both readWr_i and writeWr_i set: the access is treated as a store.
- BUS: bus_req=1 and all bus_* outputs stable until bus_ack. On bus_ack go to IDLE and retire next cycle:
  - Load: wb_data = extracted value, wb_wr = regcWr_i latched.
  - Store: wb_wr=0, wb_data = latched regcData_i.
- Store lanes: `bus_wdata = memData_i << (8*addr[1:0])`, `bus_wstrb = wmask_i << addr[1:0]` (4-bit truncate).
- Load extraction: `t = bus_rdata >> (8*addr[1:0])`.
  - Byte: t[7:0], extended from bit 7 if load_signed_i, else zero-extended.
  - Half: t[15:0], extended likewise.
  - Word: t.
- bus_ack outside BUS is ignored.
- No downstream backpressure: writeback always consumes wb_valid.

## Timing
- Reset values: state IDLE; bus_req, bus_we, bus_wstrb, wb_valid, wb_wr, misalign = 0; bus_addr, bus_wdata, wb_data, wb_addr = 0. in_ready is 0 while rst is high.
- Non-memory or misaligned op accepted at cycle T: wb_valid at T+1. Back-to-back accepts give wb_valid every cycle.
- Aligned memory op accepted at T: bus_req rises at T+1. If bus_ack arrives at T+1+k (k≥0), wb_valid is at T+2+k and in_ready returns at T+2+k.
- Bus ack in the first request cycle (k=0) is legal.
- wb_valid and misalign are single-cycle pulses.
- rst in BUS: next cycle state IDLE, bus_req=0, any concurrent or later ack is discarded, and no retire occurs. The bus tolerates abandoned requests.
- rst asserted the same cycle as bus_ack: reset wins.

## Test plan
- ALU op regcData_i=0x1234_5678, regcAddr_i=5, regcWr_i=1, accepted at T → at T+1: wb_valid=1, wb_data=0x12345678, wb_addr=5, wb_wr=1; bus_req stays 0.
- Signed byte load, addr=0x1003, bus_rdata=0x80AA_BBCC, ack after 3 wait cycles → bus_addr=0x1000, bus_wstrb=0, wb_data=0xFFFF_FF80. in_ready is low during the wait; wb_valid rises 1 cycle after ack.
- Store half, addr=0x2002, memData_i=0x0000_BEEF → bus_we=1, bus_wdata=0xBEEF_0000, bus_wstrb=1100; on retire, wb_wr=0.
- Word load at addr=0x3001 → next cycle misalign=1, wb_valid=1, wb_wr=0; bus_req never asserts.
- Unsigned half load, addr=0x4000, bus_rdata=0x1234_F00D, same-cycle ack → wb_data=0x0000_F00D, retiring at T+2.
- rst asserted during BUS, with bus_ack arriving 1 cycle later → bus_req=0, no wb_valid, in_ready=1 after rst deasserts.
